// File: rtl/cache_tag_lookup.sv
// Set-associative tag/valid/LRU lookup feeding the prefetcher: hit/miss response,
// allocate on miss, and a held miss address with a guard gap after every miss.
module cache_tag_lookup #(
    parameter int way             = 4,
    parameter int block_size_byte = 16,
    parameter int cache_size_byte = 1024,
    parameter int pf_gap          = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [31:0]              req_addr,
    output logic                     req_ready,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [$clog2(way)-1:0]   resp_way,
    output logic                     cache_miss,
    output logic [31:0]              miss_addr
);

    localparam int OFF  = $clog2(block_size_byte);
    localparam int SETS = cache_size_byte / (block_size_byte * way);
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = 32 - IDX - OFF;
    localparam int AW   = $clog2(way);
    localparam int CW   = $clog2(pf_gap + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, GAP} state_t;

    state_t              state;
    logic [CW-1:0]       gap_cnt;
    logic [31:0]         addr_q;
    logic                hit_p1;
    logic [AW-1:0]       sel_p1;

    logic                vld_arr [SETS][way];
    logic [TAG-1:0]      tag_arr [SETS][way];
    logic [AW-1:0]       age_arr [SETS][way];

    logic [IDX-1:0]      idx_q;
    logic [TAG-1:0]      tag_q;
    logic                hit;
    logic [AW-1:0]       hit_way;
    logic                inv_found;
    logic [AW-1:0]       inv_way;
    logic [AW-1:0]       lru_way;
    logic [AW-1:0]       sel;
    logic [AW-1:0]       old_age;

    assign idx_q   = addr_q[IDX+OFF-1:OFF];
    assign tag_q   = addr_q[31:IDX+OFF];
    assign old_age = age_arr[idx_q][sel_p1];

    // Descending scan so the lowest-numbered qualifying way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = way - 1; w >= 0; w--) begin
            if (vld_arr[idx_q][w] && (tag_arr[idx_q][w] == tag_q)) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (!vld_arr[idx_q][w]) begin
                inv_found = 1'b1;
                inv_way   = AW'(w);
            end
            if (age_arr[idx_q][w] == AW'(way - 1)) begin
                lru_way = AW'(w);
            end
        end
        sel = hit ? hit_way : (inv_found ? inv_way : lru_way);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            cache_miss <= 1'b0;
            miss_addr  <= '0;
            gap_cnt    <= '0;
            hit_p1     <= 1'b0;
            sel_p1     <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < way; w++) begin
                    vld_arr[s][w] <= 1'b0;
                    age_arr[s][w] <= AW'(w);
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= LOOKUP;
                        req_ready <= 1'b0;
                    end
                end
                // lookup -> update boundary: result and miss pulse registered together
                LOOKUP: begin
                    hit_p1     <= hit;
                    sel_p1     <= sel;
                    resp_valid <= 1'b1;
                    resp_hit   <= hit;
                    resp_way   <= sel;
                    if (!hit) begin
                        cache_miss <= 1'b1;
                        miss_addr  <= addr_q;
                    end
                    state <= UPDATE;
                end
                // update -> idle/gap boundary: LRU promote and allocate
                UPDATE: begin
                    resp_valid <= 1'b0;
                    cache_miss <= 1'b0;
                    for (int w = 0; w < way; w++) begin
                        if (AW'(w) == sel_p1) begin
                            age_arr[idx_q][w] <= '0;
                        end else if (age_arr[idx_q][w] < old_age) begin
                            age_arr[idx_q][w] <= age_arr[idx_q][w] + AW'(1);
                        end
                    end
                    if (hit_p1) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        vld_arr[idx_q][sel_p1] <= 1'b1;
                        gap_cnt                <= CW'(pf_gap);
                        state                  <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt <= CW'(1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request address and tag storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid && req_ready) begin
            addr_q <= req_addr;
        end
        if (state == UPDATE && !hit_p1) begin
            tag_arr[idx_q][sel_p1] <= tag_q;
        end
    end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup: expected responses are queued at issue
// and compared by a negedge monitor when resp_valid fires.
module tb_cache_tag_lookup;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic        cache_miss;
    logic [31:0] miss_addr;

    cache_tag_lookup #(
        .way(4), .block_size_byte(16), .cache_size_byte(1024), .pf_gap(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_way(resp_way), .cache_miss(cache_miss), .miss_addr(miss_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [1:0]  way;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_miss_addr = '0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'(0));
                end else begin
                    e = sb.pop_front();
                    if (!e.hit) exp_miss_addr = e.addr;
                    chk("resp_hit", 32'(resp_hit), 32'(e.hit));
                    chk("resp_way", 32'(resp_way), 32'(e.way));
                    chk("cache_miss", 32'(cache_miss), 32'(!e.hit));
                    chk("miss_addr", miss_addr, exp_miss_addr);
                end
            end else if (cache_miss) begin
                chk("stray_cache_miss", 32'(cache_miss), 32'(0));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        exp_miss_addr = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_req(input logic [31:0] a, input logic h, input logic [1:0] w);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'(1));
            req_valid = 1'b0;
            return;
        end
        e.addr = a; e.hit = h; e.way = w;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 10);
        chk("latency", 32'(n), 32'(2));
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_gap", 32'(n - 1), h ? 32'(0) : 32'(4));
    endtask

    logic [31:0] stream_addr [5];
    logic [1:0]  stream_way  [5];

    initial begin
        int   idx;
        int   nmiss;
        int   last_cyc;
        int   seen;
        exp_t e;

        // Reset values
        do_reset();
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_resp_hit", 32'(resp_hit), 32'(0));
        chk("rst_resp_way", 32'(resp_way), 32'(0));
        chk("rst_cache_miss", 32'(cache_miss), 32'(0));
        chk("rst_miss_addr", miss_addr, 32'h0);

        // First miss, same-block hit
        do_req(32'h0000_0100, 1'b0, 2'd0);
        do_req(32'h0000_0108, 1'b1, 2'd0);

        // Fill set 0, refresh way 0, then LRU victim is way 1
        do_req(32'h0000_0200, 1'b0, 2'd1);
        do_req(32'h0000_0300, 1'b0, 2'd2);
        do_req(32'h0000_0400, 1'b0, 2'd3);
        do_req(32'h0000_0100, 1'b1, 2'd0);
        do_req(32'h0000_0500, 1'b0, 2'd1);

        // Back-to-back misses with req_valid held: pulses 7 cycles apart
        stream_addr[0] = 32'h1000_0010; stream_way[0] = 2'd0;
        stream_addr[1] = 32'h2000_0010; stream_way[1] = 2'd1;
        stream_addr[2] = 32'h3000_0010; stream_way[2] = 2'd2;
        stream_addr[3] = 32'h4000_0010; stream_way[3] = 2'd3;
        stream_addr[4] = 32'h5000_0010; stream_way[4] = 2'd0;
        idx = 0; nmiss = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cache_miss) begin
                if (last_cyc >= 0) chk("miss_spacing", 32'(cyc - last_cyc), 32'(7));
                last_cyc = cyc;
                nmiss++;
            end
            if (req_ready) begin
                if (idx < 5) begin
                    req_valid = 1'b1;
                    req_addr  = stream_addr[idx];
                    e.addr = stream_addr[idx]; e.hit = 1'b0; e.way = stream_way[idx];
                    sb.push_back(e);
                    idx++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("stream_miss_count", 32'(nmiss), 32'(5));
        chk("stream_drained", 32'(sb.size()), 32'(0));

        // Reset during LOOKUP of a miss aborts it
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0600;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst_n = 1'b0;
        exp_miss_addr = '0;
        sb.delete();
        chk("abort_resp_valid", 32'(resp_valid), 32'(0));
        chk("abort_cache_miss", 32'(cache_miss), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (resp_valid || cache_miss) seen++;
        end
        chk("abort_no_activity", 32'(seen), 32'(0));
        chk("abort_miss_addr", miss_addr, 32'h0);
        do_req(32'h0000_0100, 1'b0, 2'd0);

        // Set 15 and set 0 are independent
        do_reset();
        do_req(32'h0000_00F0, 1'b0, 2'd0);
        do_req(32'h0000_0000, 1'b0, 2'd0);
        do_req(32'h0000_00F0, 1'b1, 2'd0);
        do_req(32'h0000_0000, 1'b1, 2'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_tag_lookup.md
Name: cache_tag_lookup

Overview:
- Tag-only, set-associative L1 lookup stage that sits directly upstream of the prefetcher.
- Accepts one address request at a time over a valid/ready handshake and checks it against a tag/valid/LRU array.
- Returns hit/miss, allocates on miss, and on every miss drives the prefetcher's cache_miss pulse with a held, stable address.
- Enforces a guard interval after each miss so the prefetcher's multi-cycle search/update completes before the next miss can arrive.

Parameters:
- way, 4, associativity (power of 2, 2..8).
- block_size_byte, 16, bytes per block; block offset width OFF = log2(block_size_byte) = 4.
- cache_size_byte, 1024, total capacity; sets = cache_size_byte/(block_size_byte*way) = 16; index width IDX = 4.
- pf_gap, 4, cycles after a miss during which req_ready is held low (prefetcher completion window).
- Derived: TAG = 32-IDX-OFF = 24 bits; age width AW = log2(way) = 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_addr  in  32  byte address of request.
- req_ready  out  1  block can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse: lookup result available.
- resp_hit  out  1  1 = hit, 0 = miss; valid only with resp_valid.
- resp_way  out  log2(way)  way hit or allocated; valid only with resp_valid.
- cache_miss  out  1  one-cycle pulse to prefetcher on a miss.
- miss_addr  out  32  address of the most recent miss; held until the next miss (prefetcher address input).

Behaviour:
- Address split: tag = addr[31:IDX+OFF], index = addr[IDX+OFF-1:OFF]; offset ignored.
- Storage per set and way: valid bit, TAG-bit tag, AW-bit age (0 = MRU, way-1 = LRU).
- Reset (async assert, sync release):
  - All valid bits 0; age of way w in every set = w.
  - FSM to IDLE; req_ready=1; resp_valid=0, resp_hit=0, resp_way=0, cache_miss=0, miss_addr=0; gap counter=0.
- FSM states: IDLE, LOOKUP, UPDATE, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_addr into addr_q and go to LOOKUP. req_ready drops the next cycle.
- LOOKUP (1 cycle):
  - Compare addr_q tag against all valid ways of its set.
  - Hit way = lowest-numbered matching way. Duplicate matches cannot occur by construction.
  - Miss victim = lowest-numbered invalid way; if none, the way whose age == way-1.
  - Go to UPDATE.
- UPDATE (1 cycle):
  - Selected way s gets age 0; every way in the set with age < old age(s) increments; others unchanged. Ages stay a permutation of 0..way-1.
  - On miss, also write valid=1 and tag into way s.
  - resp_valid=1, resp_hit, resp_way=s for exactly this cycle.
  - On miss: cache_miss=1 this cycle and miss_addr<=addr_q at the same edge. cache_miss and miss_addr change together.
  - Next state: hit -> IDLE; miss -> GAP with gap counter loaded to pf_gap.
- GAP:
  - req_ready=0; counter decrements each cycle; exit to IDLE when it reaches 1.
  - Result: exactly pf_gap cycles in GAP.
- Latency: request accepted at edge N -> resp_valid high in cycle N+2.
  - Hit throughput: 1 request per 3 cycles.
  - Miss throughput: 1 request per 3+pf_gap cycles.
- Boundaries:
  - req_valid is ignored while req_ready=0; requester must hold the request.
  - Index wrap: prefetcher next-line computation is not this block's concern; set 15 is a normal set.
  - Reset mid-operation aborts any pending response; no cache_miss is emitted after reset release for the aborted request.
  - cache_miss is never asserted on two consecutive cycles, and never within pf_gap cycles of a previous assertion.

Test Plan:
- Reset, then request 0x0000_0100 -> resp_valid 2 cycles later, resp_hit=0, resp_way=0, cache_miss=1 one cycle, miss_addr=0x0000_0100; req_ready low for 4 cycles after UPDATE.
- Repeat 0x0000_0108 (same block) -> resp_hit=1, resp_way=0, no cache_miss, miss_addr still 0x0000_0100.
- Fill set 0 with tags 1,2,3,4 (addrs 0x100,0x200,0x300,0x400), then hit 0x100 and request 0x500 -> miss allocates way 1 (tag 2, LRU), resp_way=1.
- Hold req_valid high continuously with alternating miss addresses -> cache_miss pulses spaced exactly 3+pf_gap=7 cycles apart.
- Assert rst_n low during LOOKUP of a miss -> no resp_valid, no cache_miss; all sets invalid afterwards, so a re-request of the same address misses.
- Requests 0x0000_00F0 (set 15) and 0x0000_0000 (set 0) -> both miss into way 0 of their respective sets; subsequent requests to the same addresses hit independently.
